// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor into a one-cycle div_by_zero result.
module seq_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ZERO} state_t;

  state_t        r_state, w_state_nx;
  logic [VW-1:0] r_rem, w_rem_nx;
  logic [DW-1:0] r_q, w_q_nx;
  logic [VW-1:0] r_d, w_d_nx;
  logic [3:0]    r_cnt, w_cnt_nx;
  logic          w_busy_nx, w_done_nx, w_dz_nx;
  logic [DW-1:0] w_quot_nx;
  logic [VW-1:0] w_remo_nx;

  // Partial remainder stays below the divisor, so only its low VW bits are stored;
  // the shifted trial value keeps the extra bit for the compare.
  logic [VW:0]   w_t;
  logic          w_ge;
  logic [VW-1:0] w_diff;

  assign w_t    = {r_rem, r_q[DW-1]};
  assign w_ge   = (w_t >= {1'b0, r_d});
  assign w_diff = w_t[VW-1:0] - r_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_rem       <= w_rem_nx;
      r_q         <= w_q_nx;
      r_d         <= w_d_nx;
      r_cnt       <= w_cnt_nx;
      busy        <= w_busy_nx;
      done        <= w_done_nx;
      quotient    <= w_quot_nx;
      remainder   <= w_remo_nx;
      div_by_zero <= w_dz_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_rem_nx   = r_rem;
    w_q_nx     = r_q;
    w_d_nx     = r_d;
    w_cnt_nx   = r_cnt;
    w_busy_nx  = busy;
    w_done_nx  = 1'b0;
    w_dz_nx    = 1'b0;
    w_quot_nx  = quotient;
    w_remo_nx  = remainder;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_q_nx    = dividend;
          w_d_nx    = divisor;
          w_rem_nx  = '0;
          w_cnt_nx  = '0;
          w_busy_nx = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
          w_state_nx = (divisor == '0) ? S_ZERO : S_CALC;
`else
          w_state_nx = S_CALC;
`endif
        end
      end
      S_CALC: begin
        w_q_nx   = {r_q[DW-2:0], w_ge};
        w_rem_nx = w_ge ? w_diff : w_t[VW-1:0];
        w_cnt_nx = r_cnt + 4'd1;
        if (r_cnt == 4'(DW-1)) begin
          w_state_nx = S_IDLE;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
          w_quot_nx  = w_q_nx;
          w_remo_nx  = w_rem_nx;
        end
      end
`ifdef DIV_ZERO_DETECT_EN
      S_ZERO: begin
        w_state_nx = S_IDLE;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b1;
        w_dz_nx    = 1'b1;
        w_quot_nx  = '1;
        w_remo_nx  = '0;
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic/timing reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted operation completes a fixed number of cycles later
  // with the arithmetic quotient/remainder.
  logic       m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [7:0] m_q = '0, p_q = '0;
  logic [3:0] m_r = '0, p_r = '0;
  logic       p_dz = 1'b0;
  int         m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_q = 0; m_r = 0; m_left = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz;
        end
      end else if (start) begin
        if (divisor == 0) begin
          p_q  = 8'hFF;
          p_r  = DZ_EN ? 4'd0 : dividend[3:0];
          p_dz = DZ_EN;
          m_left = DZ_EN ? 1 : 8;
        end else begin
          p_q  = 8'(int'(dividend) / int'(divisor));
          p_r  = 4'(int'(dividend) % int'(divisor));
          p_dz = 0;
          m_left = 8;
        end
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("done", int'(done), int'(m_done));
      check("quotient", int'(quotient), int'(m_q));
      check("remainder", int'(remainder), int'(m_r));
      check("div_by_zero", int'(div_by_zero), int'(m_dz));
    end
  end

  // Waits (bounded) for done; returns busy-cycle count and negedges elapsed.
  task automatic wait_done(output int nb, output int nn);
    nb = 0; nn = 0;
    do begin
      @(negedge clk);
      nn++;
      if (busy === 1'b1) nb++;
    end while (done !== 1'b1 && nn < 40);
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [3:0] b, input int eq, input int er,
                       input int ebusy, input string tag);
    int nb, nn;
    @(posedge clk); #2;
    start = 1; dividend = a; divisor = b;
    @(posedge clk); #2;
    start = 0;
    wait_done(nb, nn);
    check({tag, "_q"}, int'(quotient), eq);
    check({tag, "_r"}, int'(remainder), er);
    check({tag, "_busycycles"}, nb, ebusy);
  endtask

  initial begin
    int nb, nn;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dz", int'(div_by_zero), 0);
    @(posedge clk); #2;
    rst = 1;
    chk_en = 1;

    do_op(8'd30, 4'd7, 4, 2, 8, "30_7");
    do_op(8'd255, 4'd15, 17, 0, 8, "255_15");
    do_op(8'd200, 4'd3, 66, 2, 8, "200_3");
    do_op(8'd5, 4'd9, 0, 5, 8, "5_9");

    // Inputs churn while busy; the latched operands must win.
    @(posedge clk); #2;
    start = 1; dividend = 8'd100; divisor = 4'd9;
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) begin
      start = ~start; dividend = 8'($urandom); divisor = 4'($urandom);
      @(posedge clk); #2;
    end
    start = 0;
    wait_done(nb, nn);
    check("100_9_q", int'(quotient), 11);
    check("100_9_r", int'(remainder), 1);
    repeat (4) begin
      @(negedge clk);
      check("no_extra_done", int'(done), 0);
    end

    // Back-to-back: next start issued in the done cycle.
    do_op(8'd30, 4'd7, 4, 2, 8, "b2b_first");
    start = 1; dividend = 8'd200; divisor = 4'd3;
    @(posedge clk); #2;
    start = 0;
    #3;
    check("b2b_held_q", int'(quotient), 4);
    check("b2b_held_r", int'(remainder), 2);
    check("b2b_busy", int'(busy), 1);
    nn = 1;
    while (done !== 1'b1 && nn < 40) begin
      @(negedge clk);
      nn++;
    end
    check("b2b_spacing", nn, 9);
    check("b2b_q", int'(quotient), 66);
    check("b2b_r", int'(remainder), 2);

    // Zero divisor.
    do_op(8'hA6, 4'd0, 255, DZ_EN ? 0 : 6, DZ_EN ? 1 : 8, "div0");
    check("div0_flag", int'(div_by_zero), DZ_EN ? 1 : 0);

    // Reset after the fourth iteration.
    @(posedge clk); #2;
    start = 1; dividend = 8'd255; divisor = 4'd15;
    @(posedge clk); #2;
    start = 0;
    repeat (4) @(posedge clk);
    #2;
    rst = 0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_q", int'(quotient), 0);
    check("midrst_r", int'(remainder), 0);
    @(posedge clk); #2;
    rst = 1;
    do_op(8'd30, 4'd7, 4, 2, 8, "after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
